// File: rtl/pacman_pkg.sv
// Shared constants, tile codes and FSM state encoding for the pellet-eating datapath.
package pacman_pkg;

    localparam int unsigned BOARD_W       = 28;
    localparam int unsigned BOARD_H       = 31;
    localparam int unsigned BOARD_CELLS   = 868;
    localparam int unsigned PELLET_TOTAL  = 244;
    localparam int unsigned PELLET_POINTS = 10;
    localparam int unsigned POWER_POINTS  = 50;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned TILE_W    = 4;
    localparam int unsigned XY_W      = 5;
    localparam int unsigned XY_CMP_W  = XY_W + 1;
    localparam int unsigned SCORE_W   = 16;
    localparam int unsigned PELLETS_W = 8;

    localparam logic [TILE_W-1:0] TILE_EMPTY  = 4'h0;
    localparam logic [TILE_W-1:0] TILE_PELLET = 4'h1;
    localparam logic [TILE_W-1:0] TILE_POWER  = 4'h2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/board_addr_calc.sv
// Tile coordinate to linear board address (y*BOARD_W + x) plus on-board range check.
module board_addr_calc
    import pacman_pkg::*;
#(
    parameter int unsigned BOARD_W = pacman_pkg::BOARD_W,
    parameter int unsigned BOARD_H = pacman_pkg::BOARD_H
) (
    input  logic [XY_W-1:0]   tile_x_i,
    input  logic [XY_W-1:0]   tile_y_i,
    output logic [ADDR_W-1:0] addr_c,
    output logic              in_range_c
);

    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;

    assign x_ext = ADDR_W'(tile_x_i);
    assign y_ext = ADDR_W'(tile_y_i);

    // 28-wide board: y*32 - y*4 keeps the row offset to one subtractor.
    if (BOARD_W == 28) begin : g_shift
        assign addr_c = (y_ext << 5) - (y_ext << 2) + x_ext;
    end else begin : g_generic
        assign addr_c = (y_ext * ADDR_W'(BOARD_W)) + x_ext;
    end

    assign in_range_c = ({1'b0, tile_x_i} < XY_CMP_W'(BOARD_W)) &&
                        ({1'b0, tile_y_i} < XY_CMP_W'(BOARD_H));

endmodule

// File: rtl/pellet_eater.sv
// Checks Pac-Man's tile on the board RAM, clears eaten pellets, and keeps score / pellet count.
module pellet_eater
    import pacman_pkg::*;
#(
    parameter int unsigned BOARD_W      = pacman_pkg::BOARD_W,
    parameter int unsigned BOARD_H      = pacman_pkg::BOARD_H,
    parameter int unsigned PELLET_TOTAL = pacman_pkg::PELLET_TOTAL
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 req,
    input  logic [XY_W-1:0]      tile_x,
    input  logic [XY_W-1:0]      tile_y,
    output logic                 ack,
    output logic [ADDR_W-1:0]    board_read_address,
    input  logic [TILE_W-1:0]    board_data_out,
    output logic [ADDR_W-1:0]    board_write_address,
    output logic [TILE_W-1:0]    board_data_in,
    output logic                 board_we,
    input  logic                 level_restart,
    output logic [SCORE_W-1:0]   score,
    output logic [PELLETS_W-1:0] pellets_left,
    output logic                 eat_pulse,
    output logic                 power_pulse,
    output logic                 level_clear
);

    localparam logic [PELLETS_W-1:0] PELLETS_INIT = PELLETS_W'(PELLET_TOTAL);

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_c;
    logic                 in_range_c;
    logic                 is_edible_c;

    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 power_q, power_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W:0]     score_sum_c;
    logic [PELLETS_W-1:0] pellets_q, pellets_d;
    logic                 clear_q, clear_d;
    logic                 ack_q, ack_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [TILE_W-1:0]    din_q, din_d;
    logic                 eat_q, eat_d;
    logic                 pwr_q, pwr_d;

    board_addr_calc #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H)
    ) u_addr (
        .tile_x_i   (tile_x),
        .tile_y_i   (tile_y),
        .addr_c     (addr_c),
        .in_range_c (in_range_c)
    );

    assign is_edible_c = (board_data_out == TILE_PELLET) || (board_data_out == TILE_POWER);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (level_restart) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (req) state_d = in_range_c ? ST_READ : ST_DONE;
                ST_READ:  state_d = ST_CHECK;
                ST_CHECK: state_d = is_edible_c ? ST_WRITE : ST_DONE;
                ST_WRITE: state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered off the next state so they line up with the state they belong to.
    always_comb begin
        addr_d      = addr_q;
        power_d     = power_q;
        score_d     = score_q;
        pellets_d   = pellets_q;
        clear_d     = clear_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        din_d       = TILE_EMPTY;
        ack_d       = (state_d == ST_DONE);
        we_d        = (state_d == ST_WRITE);
        eat_d       = (state_d == ST_WRITE);
        pwr_d       = 1'b0;
        score_sum_c = {1'b0, score_q} +
                      (SCORE_W+1)'(power_q ? POWER_POINTS : PELLET_POINTS);

        if (state_q == ST_IDLE && req) addr_d = addr_c;
        if (state_d == ST_READ) rd_addr_d = addr_c;
        if (state_d == ST_WRITE) begin
            wr_addr_d = addr_q;
            power_d   = (board_data_out == TILE_POWER);
            pwr_d     = (board_data_out == TILE_POWER);
        end

        // Restart overrides the commit of a write that is in flight.
        if (level_restart) begin
            pellets_d = PELLETS_INIT;
            clear_d   = 1'b0;
        end else if (state_q == ST_WRITE) begin
            score_d = score_sum_c[SCORE_W] ? {SCORE_W{1'b1}} : score_sum_c[SCORE_W-1:0];
            if (pellets_q != '0) pellets_d = pellets_q - PELLETS_W'(1);
            if (pellets_q == PELLETS_W'(1)) clear_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q    <= '0;
            power_q   <= 1'b0;
            score_q   <= '0;
            pellets_q <= PELLETS_INIT;
            clear_q   <= 1'b0;
            ack_q     <= 1'b0;
            we_q      <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            din_q     <= TILE_EMPTY;
            eat_q     <= 1'b0;
            pwr_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            power_q   <= power_d;
            score_q   <= score_d;
            pellets_q <= pellets_d;
            clear_q   <= clear_d;
            ack_q     <= ack_d;
            we_q      <= we_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            din_q     <= din_d;
            eat_q     <= eat_d;
            pwr_q     <= pwr_d;
        end
    end

    assign ack                 = ack_q;
    assign board_we            = we_q;
    assign board_read_address  = rd_addr_q;
    assign board_write_address = wr_addr_q;
    assign board_data_in       = din_q;
    assign score               = score_q;
    assign pellets_left        = pellets_q;
    assign eat_pulse           = eat_q;
    assign power_pulse         = pwr_q;
    assign level_clear         = clear_q;

endmodule

// File: doc/pellet_eater.md
PELLET_EATER -- requirements
Module: pellet_eater

Interface
REQ-001 SHALL have parameter BOARD_W, default 28, tiles per board row.
REQ-002 SHALL have parameter BOARD_H, default 31, tile rows on the board.
REQ-003 SHALL have parameter PELLET_TOTAL, default 244, pellets plus power pellets per level.
REQ-004 SHALL have port Clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  1  tile-check request from the movement controller.
REQ-007 SHALL have port tile_x  input  5  Pac-Man tile column.
REQ-008 SHALL have port tile_y  input  5  Pac-Man tile row.
REQ-009 SHALL have port ack  output  1  transaction complete, one-cycle pulse.
REQ-010 SHALL have port board_read_address  output  10  read address to the game-board RAM.
REQ-011 SHALL have port board_data_out  input  4  tile code from the board; valid one cycle after the address is presented.
REQ-012 SHALL have port board_write_address  output  10  write address to the board.
REQ-013 SHALL have port board_data_in  output  4  write data to the board.
REQ-014 SHALL have port board_we  output  1  board write enable.
REQ-015 SHALL have port level_restart  input  1  start-of-level reload.
REQ-016 SHALL have port score  output  16  binary score.
REQ-017 SHALL have port pellets_left  output  8  pellets remaining in the level.
REQ-018 SHALL have port eat_pulse  output  1  one-cycle pulse when any pellet is eaten.
REQ-019 SHALL have port power_pulse  output  1  one-cycle pulse when a power pellet is eaten.
REQ-020 SHALL have port level_clear  output  1  sticky flag, set when pellets_left reaches 0.

Function
REQ-021 SHALL compute the tile address as tile_y*BOARD_W + tile_x, 10 bits, with no multiplier (y*32 - y*4 + x).
REQ-022 SHALL use the FSM states IDLE, READ, CHECK, WRITE and DONE.
REQ-023 SHALL leave IDLE only on req=1 and SHALL latch the address in that cycle; req in any other state is ignored.
REQ-024 SHALL go from IDLE to DONE, with no board access, when tile_x>=BOARD_W or tile_y>=BOARD_H.
REQ-025 SHALL, with a valid coordinate, drive board_read_address=latched address in READ, then go to CHECK.
REQ-026 SHALL, in CHECK, go to WRITE if board_data_out is TILE_PELLET (4'h1) or TILE_POWER (4'h2), and to DONE for any other code.
REQ-027 SHALL, in WRITE, for exactly one cycle assert board_we=1, board_write_address=latched address, board_data_in=TILE_EMPTY (4'h0), and eat_pulse=1.
REQ-028 SHALL also assert power_pulse=1 in WRITE when the tile code is TILE_POWER.
REQ-029 SHALL, at the end of WRITE, add 10 (pellet) or 50 (power) to score, saturating at 16'hFFFF.
REQ-030 SHALL, at the end of WRITE, decrement pellets_left, holding it at 0 (no underflow; score is still added).
REQ-031 SHALL set level_clear on the edge where pellets_left goes from 1 to 0; it stays set until level_restart or reset.
REQ-032 SHALL assert ack for exactly one cycle in DONE, then return to IDLE; latency from the req edge is 4 cycles for an eat, 3 for a non-pellet and 1 for out-of-range.
REQ-033 SHALL require the requester to drop req on ack; a req still high in the following IDLE cycle starts a new transaction.
REQ-034 SHALL, on level_restart=1, go to IDLE, reload pellets_left=PELLET_TOTAL, clear level_clear, keep score, and suppress board_we and ack that cycle; level_restart wins over a simultaneous WRITE.
REQ-035 SHALL register all outputs and SHALL NOT drive board_we outside WRITE.

Reset
REQ-036 SHALL, while Reset_n=0, immediately force: state=IDLE, ack=0, board_we=0, both addresses=0, board_data_in=0, score=0, pellets_left=PELLET_TOTAL, level_clear=0, eat_pulse=0, power_pulse=0.

Structure
REQ-037 SHALL take TILE_EMPTY/TILE_PELLET/TILE_POWER, BOARD_W/BOARD_H, BOARD_CELLS=868, PELLET_TOTAL, PELLET_POINTS=10, POWER_POINTS=50 and the state enum from shared package pacman_pkg.
REQ-038 SHALL place the address arithmetic in sub-module board_addr_calc.

Verification
REQ-039 SHALL cover: mem[59]=1, req with (3,2) -> board_we in cycle 3 to addr 59 with data 0; ack in cycle 4; score=10; pellets_left=243; eat_pulse=1 and power_pulse=0.
REQ-040 SHALL cover: mem[85]=2, req with (1,3) -> score +50, power_pulse and eat_pulse both 1 for one cycle, mem[85] reads 0 afterwards.
REQ-041 SHALL cover: mem[59]=3 (wall) -> ack in cycle 3, board_we never asserted, score and pellets_left unchanged.
REQ-042 SHALL cover: req with (28,0) and with (0,31) -> ack in cycle 1, no read or write, counters unchanged.
REQ-043 SHALL cover: 244 eats on distinct pellet cells -> level_clear rises with pellets_left=0; a 245th eat keeps 0 and adds 10; level_restart -> 244 and level_clear=0, score kept.
REQ-044 SHALL cover: Reset_n low during WRITE -> board_we drops without waiting for a clock, score=0, pellets_left=244; level_restart during WRITE -> no ack, no score change.
